orclr_event_src: RTL

//  Event front-end feeding the hardware-set input of an or-clear (write-1-to-clear) status register.
//  - Synchronises N asynchronous event lines and detects per-bit rising and/or falling edges.
//  - Applies a per-bit holdoff window.
//  - Emits single-cycle set pulses on evt_o, wired directly to the status register's set input (breg_i).
//  - Counts edges suppressed by holdoff so software can detect lost events.

---
 rtl/orclr_event_src.sv | 100 ++++++++++
 1 files changed

// File: rtl/orclr_event_src.sv
// orclr_event_src: edge-detecting event front-end with per-bit holdoff, driving the set input of a write-1-to-clear status register.
// Optional feature macro: EVT_SYNC_EN (adds a 2-FF synchroniser per line; arm time 3 cycles instead of 1).
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   evt_async_i  raw event lines
//   rise_en_i    per-bit rising-edge enable
//   fall_en_i    per-bit falling-edge enable
//   enable_i     global enable for event acceptance and holdoff loading
//   miss_clr_i   synchronous clear of the missed-event counter
//   evt_o        registered one-cycle set pulses
//   miss_cnt_o   saturating count of cycles with at least one suppressed edge
module orclr_event_src #(
    parameter int N       = 32,
    parameter int HOLDOFF = 4,
    parameter int MISS_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      evt_async_i,
    input  logic [N-1:0]      rise_en_i,
    input  logic [N-1:0]      fall_en_i,
    input  logic              enable_i,
    input  logic              miss_clr_i,
    output logic [N-1:0]      evt_o,
    output logic [MISS_W-1:0] miss_cnt_o
);
`ifdef EVT_SYNC_EN
    localparam logic [1:0] ARM = 2'd3;
`else
    localparam logic [1:0] ARM = 2'd1;
`endif
    localparam int HW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HW-1:0] HLOAD = HW'(HOLDOFF);

    logic [N-1:0] s, prev, edg, acc, sup;
    logic [1:0]   arm_cnt;
    logic         armed, any_sup;

`ifdef EVT_SYNC_EN
    logic [N-1:0] s1, s2;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= evt_async_i;
            s2 <= s1;
        end
    assign s = s2;
`else
    assign s = evt_async_i;
`endif

    // Arming waits until prev holds a real post-reset sample, so a line
    // already high at release is not mistaken for a rising edge.
    assign armed = arm_cnt == ARM;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            arm_cnt <= '0;
            prev    <= '0;
            evt_o   <= '0;
        end else begin
            arm_cnt <= armed ? arm_cnt : arm_cnt + 2'd1;
            prev    <= s;
            evt_o   <= acc;
        end

    assign edg = (s & ~prev & rise_en_i) | (~s & prev & fall_en_i);

    genvar b;
    generate
        for (b = 0; b < N; b++) begin : g_bit
            logic [HW-1:0] hcnt;
            logic          hz;
            assign hz     = hcnt == '0;
            assign acc[b] = edg[b] & armed & enable_i & hz;
            assign sup[b] = edg[b] & armed & enable_i & ~hz;
            always_ff @(posedge clk_i or posedge rst_i)
                if (rst_i)
                    hcnt <= '0;
                else if (acc[b])
                    hcnt <= HLOAD;
                else if (!hz)
                    hcnt <= hcnt - HW'(1);
        end
    endgenerate

    assign any_sup = |sup;

    // Counts cycles, not bits; a clear coinciding with a suppression keeps that one miss.
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            miss_cnt_o <= '0;
        else if (miss_clr_i)
            miss_cnt_o <= MISS_W'(any_sup);
        else if (any_sup && miss_cnt_o != '1)
            miss_cnt_o <= miss_cnt_o + MISS_W'(1);
endmodule
